// File: rtl/alu_rs_multi_if.sv
// Dispatch, CDB snoop and result handshake bundle for the ALU reservation station.
// Latency: none, wires only.
// Backpressure: disp_ready toward the dispatcher and res_ready from the CDB arbiter.
interface alu_rs_multi_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Dispatch
    logic             disp_valid;
    logic             disp_ready;
    logic [TAG_W-1:0] disp_rob;
    logic [2:0]       disp_funct3;
    logic             disp_alt;
    logic [XLEN-1:0]  disp_src1_data;
    logic [XLEN-1:0]  disp_src2_data;
    logic             disp_src1_rdy;
    logic             disp_src2_rdy;
    logic [TAG_W-1:0] disp_src1_tag;
    logic [TAG_W-1:0] disp_src2_tag;

    // Common data bus snoop ports
    logic             cdb0_valid;
    logic [TAG_W-1:0] cdb0_tag;
    logic [XLEN-1:0]  cdb0_data;
    logic             cdb1_valid;
    logic [TAG_W-1:0] cdb1_tag;
    logic [XLEN-1:0]  cdb1_data;

    // Result toward the CDB arbiter
    logic             res_valid;
    logic             res_ready;
    logic [TAG_W-1:0] res_rob;
    logic [XLEN-1:0]  res_data;

    logic [OCC_W-1:0] occupancy;

    // Environment side: dispatcher, CDB and arbiter
    modport master (
        output disp_valid, disp_rob, disp_funct3, disp_alt,
               disp_src1_data, disp_src2_data, disp_src1_rdy, disp_src2_rdy,
               disp_src1_tag, disp_src2_tag,
               cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
               res_ready,
        input  disp_ready, res_valid, res_rob, res_data, occupancy
    );

    // Reservation station side
    modport slave (
        input  disp_valid, disp_rob, disp_funct3, disp_alt,
               disp_src1_data, disp_src2_data, disp_src1_rdy, disp_src2_rdy,
               disp_src1_tag, disp_src2_tag,
               cdb0_valid, cdb0_tag, cdb0_data, cdb1_valid, cdb1_tag, cdb1_data,
               res_ready,
        output disp_ready, res_valid, res_rob, res_data, occupancy
    );
endinterface

// File: rtl/alu_rs_multi.sv
// Integer ALU reservation station: DEPTH entries, dual-CDB wakeup, oldest-ready issue.
// Latency: ready operands give a result 1 cycle after the dispatch edge; wakeup-to-issue 1 cycle.
// Backpressure: disp_ready low when full; result register holds while res_valid && !res_ready.
module alu_rs_multi #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int TAG_W = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    alu_rs_multi_if.slave bus
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int SH_W  = $clog2(XLEN);

    // age: 0 is the oldest busy entry; ranks of busy entries are always distinct
    typedef struct packed {
        logic [TAG_W-1:0] rob;
        logic [2:0]       f3;
        logic             alt;
        logic [XLEN-1:0]  s1_dat;
        logic             s1_rdy;
        logic [TAG_W-1:0] s1_tag;
        logic [XLEN-1:0]  s2_dat;
        logic             s2_rdy;
        logic [TAG_W-1:0] s2_tag;
        logic [IDX_W-1:0] age;
    } ent_t;

    logic [DEPTH-1:0] busy_q, busy_d;
    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             res_vld_q, res_vld_d;
    logic [TAG_W-1:0] res_rob_q, res_rob_d;
    logic [XLEN-1:0]  res_dat_q, res_dat_d;

    logic             disp_fire;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             iss_any;
    logic             iss_fire;
    logic [IDX_W-1:0] iss_idx;
    logic [IDX_W-1:0] iss_age;
    logic             out_free;
    ent_t             new_ent;
    logic [XLEN-1:0]  op_a, op_b, alu_res;
    logic [SH_W-1:0]  sh;

    assign bus.disp_ready = (occ_q != OCC_W'(DEPTH));
    assign bus.occupancy  = occ_q;
    assign bus.res_valid  = res_vld_q;
    assign bus.res_rob    = res_rob_q;
    assign bus.res_data   = res_dat_q;

    assign out_free  = !res_vld_q || bus.res_ready;
    assign disp_fire = bus.disp_valid && bus.disp_ready && !flush;
    assign iss_fire  = iss_any && out_free;

    // Lowest-index free slot, from registered busy bits only
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!busy_q[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Oldest busy entry whose operands were both ready at the start of the cycle
    always_comb begin
        iss_any = 1'b0;
        iss_idx = '0;
        iss_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (busy_q[i] && ent_q[i].s1_rdy && ent_q[i].s2_rdy &&
                (!iss_any || ent_q[i].age < iss_age)) begin
                iss_any = 1'b1;
                iss_idx = IDX_W'(i);
                iss_age = ent_q[i].age;
            end
        end
    end

    // ALU on the selected entry's registered operands
    always_comb begin
        op_a = ent_q[iss_idx].s1_dat;
        op_b = ent_q[iss_idx].s2_dat;
        sh   = op_b[SH_W-1:0];
        case (ent_q[iss_idx].f3)
            3'b000:  alu_res = ent_q[iss_idx].alt ? (op_a - op_b) : (op_a + op_b);
            3'b001:  alu_res = op_a << sh;
            3'b010:  alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            3'b011:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            3'b100:  alu_res = op_a ^ op_b;
            3'b101:  alu_res = ent_q[iss_idx].alt ? XLEN'($signed(op_a) >>> sh) : (op_a >> sh);
            3'b110:  alu_res = op_a | op_b;
            default: alu_res = op_a & op_b;
        endcase
    end

    // Incoming entry, with same-cycle CDB capture for operands still pending
    always_comb begin
        new_ent.rob    = bus.disp_rob;
        new_ent.f3     = bus.disp_funct3;
        new_ent.alt    = bus.disp_alt;
        new_ent.s1_dat = bus.disp_src1_data;
        new_ent.s1_rdy = bus.disp_src1_rdy;
        new_ent.s1_tag = bus.disp_src1_tag;
        new_ent.s2_dat = bus.disp_src2_data;
        new_ent.s2_rdy = bus.disp_src2_rdy;
        new_ent.s2_tag = bus.disp_src2_tag;
        // The survivors after an issue hold ranks 0..occ-2, so the newcomer takes the next rank
        new_ent.age    = IDX_W'(occ_q - OCC_W'(iss_fire));
        if (!bus.disp_src1_rdy) begin
            if (bus.cdb0_valid && bus.cdb0_tag == bus.disp_src1_tag) begin
                new_ent.s1_dat = bus.cdb0_data;
                new_ent.s1_rdy = 1'b1;
            end else if (bus.cdb1_valid && bus.cdb1_tag == bus.disp_src1_tag) begin
                new_ent.s1_dat = bus.cdb1_data;
                new_ent.s1_rdy = 1'b1;
            end
        end
        if (!bus.disp_src2_rdy) begin
            if (bus.cdb0_valid && bus.cdb0_tag == bus.disp_src2_tag) begin
                new_ent.s2_dat = bus.cdb0_data;
                new_ent.s2_rdy = 1'b1;
            end else if (bus.cdb1_valid && bus.cdb1_tag == bus.disp_src2_tag) begin
                new_ent.s2_dat = bus.cdb1_data;
                new_ent.s2_rdy = 1'b1;
            end
        end
    end

    // Entry next state: wakeup, issue release with age compaction, dispatch write
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (busy_q[i] && !ent_q[i].s1_rdy) begin
                if (bus.cdb0_valid && bus.cdb0_tag == ent_q[i].s1_tag) begin
                    ent_d[i].s1_dat = bus.cdb0_data;
                    ent_d[i].s1_rdy = 1'b1;
                end else if (bus.cdb1_valid && bus.cdb1_tag == ent_q[i].s1_tag) begin
                    ent_d[i].s1_dat = bus.cdb1_data;
                    ent_d[i].s1_rdy = 1'b1;
                end
            end
            if (busy_q[i] && !ent_q[i].s2_rdy) begin
                if (bus.cdb0_valid && bus.cdb0_tag == ent_q[i].s2_tag) begin
                    ent_d[i].s2_dat = bus.cdb0_data;
                    ent_d[i].s2_rdy = 1'b1;
                end else if (bus.cdb1_valid && bus.cdb1_tag == ent_q[i].s2_tag) begin
                    ent_d[i].s2_dat = bus.cdb1_data;
                    ent_d[i].s2_rdy = 1'b1;
                end
            end
            if (iss_fire && iss_idx == IDX_W'(i)) begin
                busy_d[i] = 1'b0;
            end else if (iss_fire && busy_q[i] && ent_q[i].age > iss_age) begin
                ent_d[i].age = ent_q[i].age - 1'b1;
            end
        end
        if (disp_fire) begin
            ent_d[free_idx]  = new_ent;
            busy_d[free_idx] = 1'b1;
        end
        occ_d = occ_q + OCC_W'(disp_fire) - OCC_W'(iss_fire);
    end

    // Result holding register: load on issue, drop once accepted with nothing to follow
    always_comb begin
        res_vld_d = res_vld_q;
        res_rob_d = res_rob_q;
        res_dat_d = res_dat_q;
        if (iss_fire) begin
            res_vld_d = 1'b1;
            res_rob_d = ent_q[iss_idx].rob;
            res_dat_d = alu_res;
        end else if (bus.res_ready) begin
            res_vld_d = 1'b0;
        end
    end

    // State registers; flush outranks dispatch, issue and wakeup
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q    <= '0;
            occ_q     <= '0;
            res_vld_q <= 1'b0;
            res_rob_q <= '0;
            res_dat_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else if (flush) begin
            busy_q    <= '0;
            occ_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            occ_q     <= occ_d;
            res_vld_q <= res_vld_d;
            res_rob_q <= res_rob_d;
            res_dat_q <= res_dat_d;
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_multi.sv
module tb_alu_rs_multi;
    logic clock;
    logic reset;
    logic flush;
    int   compared;
    int   failed;

    alu_rs_multi_if #(.XLEN(32), .DEPTH(4), .TAG_W(6)) bus ();

    alu_rs_multi #(.XLEN(32), .DEPTH(4), .TAG_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Inputs change and outputs are sampled on the falling edge
    task automatic tick();
        @(negedge clock);
    endtask

    task automatic clr_in();
        bus.disp_valid = 1'b0;
        bus.cdb0_valid = 1'b0;
        bus.cdb1_valid = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic set_disp(input logic [5:0] rob, input logic [2:0] f3, input logic alt,
                            input logic [31:0] a, input logic ar, input logic [5:0] at,
                            input logic [31:0] b, input logic br, input logic [5:0] bt);
        bus.disp_valid     = 1'b1;
        bus.disp_rob       = rob;
        bus.disp_funct3    = f3;
        bus.disp_alt       = alt;
        bus.disp_src1_data = a;
        bus.disp_src1_rdy  = ar;
        bus.disp_src1_tag  = at;
        bus.disp_src2_data = b;
        bus.disp_src2_rdy  = br;
        bus.disp_src2_tag  = bt;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clr_in();
        set_disp(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.disp_valid = 1'b0;
        bus.cdb0_tag = 0; bus.cdb0_data = 0; bus.cdb1_tag = 0; bus.cdb1_data = 0;
        bus.res_ready = 1'b1;
        tick(); tick();
        compared++; if (bus.res_valid !== 1'b0) begin failed++; $display("FAIL rst_res_valid got %0b want 0", bus.res_valid); end
        compared++; if (bus.occupancy !== 3'd0) begin failed++; $display("FAIL rst_occupancy got %0d want 0", bus.occupancy); end
        compared++; if (bus.disp_ready !== 1'b1) begin failed++; $display("FAIL rst_disp_ready got %0b want 1", bus.disp_ready); end
        compared++; if (bus.res_rob !== 6'd0) begin failed++; $display("FAIL rst_res_rob got %0d want 0", bus.res_rob); end
        compared++; if (bus.res_data !== 32'd0) begin failed++; $display("FAIL rst_res_data got %h want 0", bus.res_data); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_add();
        set_disp(5, 3'b000, 0, 32'd7, 1, 0, 32'hFFFF_FFFF, 1, 0);
        tick(); clr_in();
        compared++; if (bus.res_valid !== 1'b0) begin failed++; $display("FAIL add_early got %0b want 0", bus.res_valid); end
        compared++; if (bus.occupancy !== 3'd1) begin failed++; $display("FAIL add_occ got %0d want 1", bus.occupancy); end
        tick();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd5 || bus.res_data !== 32'd6) begin
            failed++; $display("FAIL add_result got v=%0b rob=%0d data=%h want v=1 rob=5 data=6", bus.res_valid, bus.res_rob, bus.res_data); end
        compared++; if (bus.occupancy !== 3'd0) begin failed++; $display("FAIL add_occ_after got %0d want 0", bus.occupancy); end
        tick();
        compared++; if (bus.res_valid !== 1'b0) begin failed++; $display("FAIL add_drain got %0b want 0", bus.res_valid); end
    endtask

    task automatic test_wakeup_sra_slt();
        set_disp(3, 3'b101, 1, 32'h8000_0000, 1, 0, 32'd0, 0, 6'd9);
        tick(); clr_in();
        // Wrong tag on the bus must not wake the entry
        bus.cdb0_valid = 1'b1; bus.cdb0_tag = 6'd8; bus.cdb0_data = 32'h4;
        tick(); clr_in();
        tick();
        compared++; if (bus.res_valid !== 1'b0) begin failed++; $display("FAIL sra_no_wake got %0b want 0", bus.res_valid); end
        bus.cdb1_valid = 1'b1; bus.cdb1_tag = 6'd9; bus.cdb1_data = 32'h24;
        tick(); clr_in();
        compared++; if (bus.res_valid !== 1'b0) begin failed++; $display("FAIL sra_same_cycle got %0b want 0", bus.res_valid); end
        tick();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd3 || bus.res_data !== 32'hF800_0000) begin
            failed++; $display("FAIL sra_result got v=%0b rob=%0d data=%h want v=1 rob=3 data=f8000000", bus.res_valid, bus.res_rob, bus.res_data); end
        set_disp(10, 3'b010, 0, 32'hFFFF_FFFF, 1, 0, 32'd1, 1, 0);
        tick();
        set_disp(11, 3'b011, 0, 32'hFFFF_FFFF, 1, 0, 32'd1, 1, 0);
        tick(); clr_in();
        compared++; if (bus.res_rob !== 6'd10 || bus.res_data !== 32'd1) begin
            failed++; $display("FAIL slt_result got rob=%0d data=%h want rob=10 data=1", bus.res_rob, bus.res_data); end
        tick();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd11 || bus.res_data !== 32'd0) begin
            failed++; $display("FAIL sltu_result got v=%0b rob=%0d data=%h want v=1 rob=11 data=0", bus.res_valid, bus.res_rob, bus.res_data); end
        tick();
    endtask

    task automatic test_alu_back_to_back();
        logic [2:0]  f3 [4];
        logic        alt [4];
        logic [31:0] a [4];
        logic [31:0] b [4];
        logic [31:0] exp [4];
        f3[0] = 3'b000; alt[0] = 1; a[0] = 32'd5;          b[0] = 32'd7;     exp[0] = 32'hFFFF_FFFE;
        f3[1] = 3'b001; alt[1] = 0; a[1] = 32'd1;          b[1] = 32'h3F;    exp[1] = 32'h8000_0000;
        f3[2] = 3'b101; alt[2] = 0; a[2] = 32'h8000_0000;  b[2] = 32'd4;     exp[2] = 32'h0800_0000;
        f3[3] = 3'b111; alt[3] = 0; a[3] = 32'h0000_F0F0; b[3] = 32'hFF00;  exp[3] = 32'h0000_F000;
        for (int k = 0; k < 5; k++) begin
            if (k < 4) set_disp(6'(40 + k), f3[k], alt[k], a[k], 1, 0, b[k], 1, 0);
            else clr_in();
            tick();
            if (k > 0) begin
                compared++;
                if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'(39 + k) || bus.res_data !== exp[k-1]) begin
                    failed++; $display("FAIL b2b_op%0d got v=%0b rob=%0d data=%h want v=1 rob=%0d data=%h",
                                       k - 1, bus.res_valid, bus.res_rob, bus.res_data, 39 + k, exp[k-1]); end
            end
        end
        tick();
    endtask

    task automatic test_full();
        for (int k = 0; k < 4; k++) begin
            set_disp(6'(20 + k), 3'b000, 0, 32'd0, 0, 6'd12, 32'(k + 1), 1, 0);
            tick();
        end
        clr_in();
        compared++; if (bus.occupancy !== 3'd4 || bus.disp_ready !== 1'b0) begin
            failed++; $display("FAIL full_state got occ=%0d rdy=%0b want occ=4 rdy=0", bus.occupancy, bus.disp_ready); end
        set_disp(24, 3'b000, 0, 32'd1, 1, 0, 32'd1, 1, 0);
        tick(); clr_in();
        compared++; if (bus.occupancy !== 3'd4 || bus.res_valid !== 1'b0) begin
            failed++; $display("FAIL full_ignore got occ=%0d v=%0b want occ=4 v=0", bus.occupancy, bus.res_valid); end
        bus.cdb0_valid = 1'b1; bus.cdb0_tag = 6'd12; bus.cdb0_data = 32'd2;
        tick(); clr_in();
        for (int k = 0; k < 4; k++) begin
            tick();
            compared++;
            if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'(20 + k) || bus.res_data !== 32'(3 + k)) begin
                failed++; $display("FAIL full_order%0d got v=%0b rob=%0d data=%h want v=1 rob=%0d data=%0h",
                                   k, bus.res_valid, bus.res_rob, bus.res_data, 20 + k, 3 + k); end
        end
        tick();
        compared++; if (bus.occupancy !== 3'd0 || bus.res_valid !== 1'b0) begin
            failed++; $display("FAIL full_drained got occ=%0d v=%0b want occ=0 v=0", bus.occupancy, bus.res_valid); end
    endtask

    task automatic test_bypass();
        set_disp(1, 3'b000, 0, 32'd0, 0, 6'd7, 32'd1, 1, 0);
        bus.cdb0_valid = 1'b1; bus.cdb0_tag = 6'd7; bus.cdb0_data = 32'h10;
        tick(); clr_in();
        tick();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd1 || bus.res_data !== 32'h11) begin
            failed++; $display("FAIL bypass_result got v=%0b rob=%0d data=%h want v=1 rob=1 data=11", bus.res_valid, bus.res_rob, bus.res_data); end
        tick();
    endtask

    task automatic test_backpressure();
        bus.res_ready = 1'b0;
        set_disp(30, 3'b100, 0, 32'hF0, 1, 0, 32'hFF, 1, 0);
        tick();
        set_disp(31, 3'b110, 0, 32'h100, 1, 0, 32'h1, 1, 0);
        tick(); clr_in();
        for (int k = 0; k < 3; k++) begin
            compared++;
            if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd30 || bus.res_data !== 32'h0F || bus.occupancy !== 3'd1) begin
                failed++; $display("FAIL hold%0d got v=%0b rob=%0d data=%h occ=%0d want v=1 rob=30 data=f occ=1",
                                   k, bus.res_valid, bus.res_rob, bus.res_data, bus.occupancy); end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_rob !== 6'd31 || bus.res_data !== 32'h101 || bus.occupancy !== 3'd0) begin
            failed++; $display("FAIL hold_release got v=%0b rob=%0d data=%h occ=%0d want v=1 rob=31 data=101 occ=0",
                               bus.res_valid, bus.res_rob, bus.res_data, bus.occupancy); end
        tick();
    endtask

    task automatic test_flush();
        bus.res_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            set_disp(6'(50 + k), 3'b000, 0, 32'(k), 1, 0, 32'd1, 1, 0);
            tick();
        end
        clr_in();
        compared++; if (bus.occupancy !== 3'd3 || bus.res_valid !== 1'b1 || bus.res_rob !== 6'd50) begin
            failed++; $display("FAIL flush_pre got occ=%0d v=%0b rob=%0d want occ=3 v=1 rob=50", bus.occupancy, bus.res_valid, bus.res_rob); end
        flush = 1'b1;
        set_disp(60, 3'b000, 0, 32'd1, 1, 0, 32'd1, 1, 0);
        tick(); clr_in();
        compared++; if (bus.occupancy !== 3'd0 || bus.res_valid !== 1'b0 || bus.disp_ready !== 1'b1) begin
            failed++; $display("FAIL flush_clear got occ=%0d v=%0b rdy=%0b want occ=0 v=0 rdy=1", bus.occupancy, bus.res_valid, bus.disp_ready); end
        bus.res_ready = 1'b1;
        tick(); tick();
        compared++; if (bus.occupancy !== 3'd0 || bus.res_valid !== 1'b0) begin
            failed++; $display("FAIL flush_drop got occ=%0d v=%0b want occ=0 v=0", bus.occupancy, bus.res_valid); end
    endtask

    task automatic test_reset_mid();
        set_disp(2, 3'b000, 0, 32'd3, 1, 0, 32'd4, 1, 0);
        tick();
        set_disp(4, 3'b000, 0, 32'd0, 0, 6'd33, 32'd4, 1, 0);
        tick(); clr_in();
        compared++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd7 || bus.occupancy !== 3'd1) begin
            failed++; $display("FAIL rstmid_pre got v=%0b data=%h occ=%0d want v=1 data=7 occ=1", bus.res_valid, bus.res_data, bus.occupancy); end
        #2 reset = 1'b0;
        #1;
        compared++; if (bus.res_valid !== 1'b0 || bus.occupancy !== 3'd0 || bus.res_data !== 32'd0 || bus.res_rob !== 6'd0) begin
            failed++; $display("FAIL rstmid_async got v=%0b occ=%0d rob=%0d data=%h want all 0",
                               bus.res_valid, bus.occupancy, bus.res_rob, bus.res_data); end
        tick();
        reset = 1'b1;
        tick();
        compared++; if (bus.disp_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            failed++; $display("FAIL rstmid_after got rdy=%0b v=%0b want rdy=1 v=0", bus.disp_ready, bus.res_valid); end
    endtask

    initial begin
        compared = 0;
        failed   = 0;
        test_reset();
        test_add();
        test_wakeup_sra_slt();
        test_alu_back_to_back();
        test_full();
        test_bypass();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end
endmodule
